// File: rtl/core_bp_upd_ctrl.sv
// Update scheduler and table-clear sequencer for the core branch predictor.
// Resolved-branch records from ID are queued in a small FIFO and drained at
// most one per cycle into the predictor update port, unless fetch holds off
// writes. A clear request sweeps every PHT/BHT index through the write port.
module core_bp_upd_ctrl #(
  parameter int DEPTH       = 4,
  parameter int PHT_ENTRIES = 128,
  parameter int BHT_ENTRIES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     br_valid,
  input  logic [5:0]               br_pc,
  input  logic                     br_taken,
  input  logic                     br_pred_right,
  input  logic [3:0]               br_bhr,
  input  logic [1:0]               br_pht,
  output logic                     br_ready,
  input  logic                     upd_hold,
  input  logic                     clear_req,
  output logic                     update_BP,
  output logic [5:0]               id_pc,
  output logic                     taken,
  output logic                     pred_right,
  output logic [3:0]               BHR_in,
  output logic [1:0]               delayed_PHT,
  output logic                     clr_we,
  output logic                     clr_bht_we,
  output logic [6:0]               clr_index,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [7:0]               drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = 14;
  localparam logic [6:0] LAST_IDX = 7'(PHT_ENTRIES - 1);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t           state, state_nx;
  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [REC_W-1:0] head;
  logic             push, pop, flush, drop, clr_last;

  // Queue control: a clear request in RUN flushes the queue and swallows any
  // record arriving in the same cycle; no pop is launched into a sweep.
  assign flush = (state == RUN) && clear_req;
  assign push  = br_valid && br_ready && !clear_req;
  assign drop  = br_valid && !br_ready;
  assign pop   = (state == RUN) && !clear_req && (q_count != '0) && !upd_hold;
  assign head  = mem[rd_ptr];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // Next-state and sweep/handshake strobes decoded from the registered state
  always_comb begin
    state_nx   = state;
    br_ready   = 1'b0;
    clr_we     = 1'b0;
    clr_busy   = 1'b0;
    clr_bht_we = 1'b0;
    clr_last   = 1'b0;
    case (state)
      RUN: begin
        br_ready = (q_count < CNT_W'(DEPTH));
        if (clear_req) state_nx = CLEAR;
      end
      CLEAR: begin
        clr_we     = 1'b1;
        clr_busy   = 1'b1;
        clr_bht_we = ({1'b0, clr_index} < 8'(BHT_ENTRIES));
        clr_last   = (clr_index == LAST_IDX);
        if (clr_last) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {br_pc, br_taken, br_pred_right, br_bhr, br_pht};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CNT_W'(1);
        2'b01:   q_count <= q_count - CNT_W'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Update port: strobe follows the pop, data holds between pops
  always_ff @(posedge clk) begin
    if (rst) begin
      update_BP   <= 1'b0;
      id_pc       <= '0;
      taken       <= 1'b0;
      pred_right  <= 1'b0;
      BHR_in      <= '0;
      delayed_PHT <= '0;
    end else begin
      update_BP <= pop;
      if (pop) {id_pc, taken, pred_right, BHR_in, delayed_PHT} <= head;
    end
  end

  // Sweep index and end-of-clear pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_index <= '0;
      clr_done  <= 1'b0;
    end else begin
      clr_done <= clr_last;
      if (state == CLEAR && !clr_last) clr_index <= clr_index + 7'd1;
      else                              clr_index <= '0;
    end
  end

  // Saturating count of records refused while not ready
  always_ff @(posedge clk) begin
    if (rst)                           drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_core_bp_upd_ctrl.sv
// Directed, table-driven bench for core_bp_upd_ctrl, plus hand-written
// sequences for the clear sweep, reset mid-sweep and drop saturation.
module tb_core_bp_upd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       br_valid;
  logic [5:0] br_pc;
  logic       br_taken;
  logic       br_pred_right;
  logic [3:0] br_bhr;
  logic [1:0] br_pht;
  logic       br_ready;
  logic       upd_hold;
  logic       clear_req;
  logic       update_BP;
  logic [5:0] id_pc;
  logic       taken;
  logic       pred_right;
  logic [3:0] BHR_in;
  logic [1:0] delayed_PHT;
  logic       clr_we;
  logic       clr_bht_we;
  logic [6:0] clr_index;
  logic       clr_busy;
  logic       clr_done;
  logic [2:0] q_count;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        valid;
    logic [13:0] rec;
    logic        hold;
    logic        e_upd;
    logic [13:0] e_rec;
    logic        e_rdy;
    logic [2:0]  e_q;
    logic [7:0]  e_drop;
  } vec_t;

  localparam logic [13:0] REC_A = {6'h2A, 1'b1, 1'b1, 4'h5, 2'b10};
  localparam logic [13:0] REC_B = {6'h11, 1'b0, 1'b1, 4'h3, 2'b01};
  localparam logic [13:0] REC_C = {6'h3F, 1'b1, 1'b0, 4'hA, 2'b11};
  localparam logic [13:0] REC_D = {6'h05, 1'b0, 1'b0, 4'hF, 2'b00};
  localparam logic [13:0] REC_E = {6'h20, 1'b1, 1'b1, 4'h0, 2'b10};
  localparam logic [13:0] Z     = 14'h0;

  vec_t vec [33];

  core_bp_upd_ctrl #(.DEPTH(4), .PHT_ENTRIES(128), .BHT_ENTRIES(8)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_pc(br_pc), .br_taken(br_taken),
    .br_pred_right(br_pred_right), .br_bhr(br_bhr), .br_pht(br_pht),
    .br_ready(br_ready), .upd_hold(upd_hold), .clear_req(clear_req),
    .update_BP(update_BP), .id_pc(id_pc), .taken(taken),
    .pred_right(pred_right), .BHR_in(BHR_in), .delayed_PHT(delayed_PHT),
    .clr_we(clr_we), .clr_bht_we(clr_bht_we), .clr_index(clr_index),
    .clr_busy(clr_busy), .clr_done(clr_done), .q_count(q_count),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic valid, input logic [13:0] rec,
                              input logic hold, input logic e_upd,
                              input logic [13:0] e_rec, input logic e_rdy,
                              input logic [2:0] e_q, input logic [7:0] e_drop);
    vec_t v;
    v.valid = valid; v.rec = rec; v.hold = hold; v.e_upd = e_upd;
    v.e_rec = e_rec; v.e_rdy = e_rdy; v.e_q = e_q; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [13:0] rec,
                               input logic hold, input logic clr);
    br_valid = valid;
    {br_pc, br_taken, br_pred_right, br_bhr, br_pht} = rec;
    upd_hold  = hold;
    clear_req = clr;
  endtask

  initial begin
    vec[0]  = mk(1, REC_A, 0, 0, Z,     1, 0, 0);
    vec[1]  = mk(0, Z,     0, 0, Z,     1, 1, 0);
    vec[2]  = mk(0, Z,     1, 1, REC_A, 1, 0, 0);
    vec[3]  = mk(1, REC_B, 1, 0, Z,     1, 0, 0);
    vec[4]  = mk(1, REC_C, 1, 0, Z,     1, 1, 0);
    vec[5]  = mk(1, REC_D, 1, 0, Z,     1, 2, 0);
    vec[6]  = mk(1, REC_A, 1, 0, Z,     1, 3, 0);
    vec[7]  = mk(1, REC_E, 1, 0, Z,     0, 4, 0);
    vec[8]  = mk(0, Z,     0, 0, Z,     0, 4, 1);
    vec[9]  = mk(0, Z,     0, 1, REC_B, 1, 3, 1);
    vec[10] = mk(0, Z,     0, 1, REC_C, 1, 2, 1);
    vec[11] = mk(0, Z,     0, 1, REC_D, 1, 1, 1);
    vec[12] = mk(0, Z,     0, 1, REC_A, 1, 0, 1);
    vec[13] = mk(1, REC_B, 1, 0, Z,     1, 0, 1);
    vec[14] = mk(1, REC_C, 1, 0, Z,     1, 1, 1);
    vec[15] = mk(0, Z,     1, 0, Z,     1, 2, 1);
    vec[16] = mk(0, Z,     1, 0, Z,     1, 2, 1);
    vec[17] = mk(0, Z,     0, 0, Z,     1, 2, 1);
    vec[18] = mk(0, Z,     0, 1, REC_B, 1, 1, 1);
    vec[19] = mk(0, Z,     0, 1, REC_C, 1, 0, 1);
    vec[20] = mk(1, REC_D, 0, 0, Z,     1, 0, 1);
    vec[21] = mk(1, REC_A, 0, 0, Z,     1, 1, 1);
    vec[22] = mk(0, Z,     0, 1, REC_D, 1, 1, 1);
    vec[23] = mk(0, Z,     0, 1, REC_A, 1, 0, 1);
    vec[24] = mk(1, REC_B, 1, 0, Z,     1, 0, 1);
    vec[25] = mk(1, REC_C, 1, 0, Z,     1, 1, 1);
    vec[26] = mk(1, REC_D, 1, 0, Z,     1, 2, 1);
    vec[27] = mk(1, REC_A, 1, 0, Z,     1, 3, 1);
    vec[28] = mk(1, REC_E, 0, 0, Z,     0, 4, 1);
    vec[29] = mk(0, Z,     0, 1, REC_B, 1, 3, 2);
    vec[30] = mk(0, Z,     1, 1, REC_C, 1, 2, 2);
    vec[31] = mk(1, REC_B, 1, 0, Z,     1, 2, 2);
    vec[32] = mk(0, Z,     1, 0, Z,     1, 3, 2);

    rst = 1'b1;
    applyStimulus(0, Z, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_update_BP", update_BP, 0);
    checkOutput("rst_rec", {id_pc, taken, pred_right, BHR_in, delayed_PHT}, 0);
    checkOutput("rst_br_ready", br_ready, 1);
    checkOutput("rst_q_count", q_count, 0);
    checkOutput("rst_drop_cnt", drop_cnt, 0);
    checkOutput("rst_clr", {clr_we, clr_bht_we, clr_busy, clr_done}, 0);
    checkOutput("rst_clr_index", clr_index, 0);

    $display("[TB] table vectors");
    for (int i = 0; i < 33; i++) begin
      checkOutput($sformatf("v%0d_update_BP", i), update_BP, vec[i].e_upd);
      if (vec[i].e_upd)
        checkOutput($sformatf("v%0d_rec", i),
                    {id_pc, taken, pred_right, BHR_in, delayed_PHT}, vec[i].e_rec);
      checkOutput($sformatf("v%0d_br_ready", i), br_ready, vec[i].e_rdy);
      checkOutput($sformatf("v%0d_q_count", i), q_count, vec[i].e_q);
      checkOutput($sformatf("v%0d_drop_cnt", i), drop_cnt, vec[i].e_drop);
      checkOutput($sformatf("v%0d_clr_busy", i), clr_busy, 0);
      applyStimulus(vec[i].valid, vec[i].rec, vec[i].hold, 1'b0);
      tick();
    end

    $display("[TB] clear sweep with 3 queued records and a same-cycle push");
    checkOutput("pre_clr_q_count", q_count, 3);
    applyStimulus(1, REC_E, 1, 1);
    tick();
    checkOutput("clr_q_flushed", q_count, 0);
    checkOutput("clr_br_ready", br_ready, 0);
    for (int k = 0; k < 128; k++) begin
      checkOutput($sformatf("sweep%0d_index", k), clr_index, k);
      checkOutput($sformatf("sweep%0d_we", k), {clr_busy, clr_we}, 2'b11);
      checkOutput($sformatf("sweep%0d_bht_we", k), clr_bht_we, (k < 8) ? 1 : 0);
      checkOutput($sformatf("sweep%0d_update_BP", k), update_BP, 0);
      checkOutput($sformatf("sweep%0d_done", k), clr_done, 0);
      applyStimulus(k == 10, REC_E, k[0], k == 50);
      tick();
    end
    checkOutput("end_clr_done", clr_done, 1);
    checkOutput("end_clr_busy", {clr_busy, clr_we, clr_bht_we}, 0);
    checkOutput("end_clr_index", clr_index, 0);
    checkOutput("end_br_ready", br_ready, 1);
    checkOutput("end_q_count", q_count, 0);
    checkOutput("end_drop_cnt", drop_cnt, 3);
    applyStimulus(0, Z, 0, 0);
    tick();
    checkOutput("post_clr_done", clr_done, 0);
    tick();
    checkOutput("post_no_update", update_BP, 0);

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(0, Z, 0, 1);
    tick();
    applyStimulus(0, Z, 0, 0);
    for (int k = 0; k <= 60; k++) begin
      checkOutput($sformatf("rsweep%0d_index", k), clr_index, k);
      if (k == 60) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    checkOutput("rmid_busy", {clr_busy, clr_we, clr_bht_we}, 0);
    checkOutput("rmid_index", clr_index, 0);
    checkOutput("rmid_drop_cnt", drop_cnt, 0);
    checkOutput("rmid_q_count", q_count, 0);
    checkOutput("rmid_br_ready", br_ready, 1);
    for (int c = 0; c < 140; c++) begin
      checkOutput($sformatf("rmid%0d_no_done", c), {clr_done, clr_busy}, 0);
      tick();
    end

    $display("[TB] drop counter saturation");
    applyStimulus(1, REC_A, 1, 0);
    for (int c = 0; c < 304; c++) begin
      if (c == 104) checkOutput("sat_mid_drop_cnt", drop_cnt, 100);
      tick();
    end
    applyStimulus(0, Z, 1, 0);
    checkOutput("sat_drop_cnt", drop_cnt, 255);
    checkOutput("sat_q_count", q_count, 4);
    checkOutput("sat_br_ready", br_ready, 0);
    tick();
    checkOutput("sat_hold_no_update", update_BP, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
